// File: rtl/dds_pkg.sv
// Shared constants for the DDS key controller: waveform codes, frequency step table,
// FSM state encoding and pending-key bit positions (DDS_KEY_PHASE_EN adds the phase key).
package dds_pkg;

  localparam logic [1:0] WAVE_SINE     = 2'd0;
  localparam logic [1:0] WAVE_SQUARE   = 2'd1;
  localparam logic [1:0] WAVE_TRIANGLE = 2'd2;
  localparam logic [1:0] WAVE_SAWTOOTH = 2'd3;

  // Indexed by step_idx: 1 Hz, 10 Hz, 100 Hz, 1 kHz increments at 50 MHz
  localparam logic [3:0][31:0] STEP_LUT = {32'd85899, 32'd8590, 32'd859, 32'd86};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2
  } dds_state_e;

  // Lower index = higher priority when several keys are pending
  localparam int KEY_WAVE = 0;
  localparam int KEY_STEP = 1;
  localparam int KEY_UP   = 2;
  localparam int KEY_DOWN = 3;
`ifdef DDS_KEY_PHASE_EN
  localparam int KEY_PHASE = 4;
  localparam int NUM_KEYS  = 5;
  localparam logic [11:0] PHASE_INC = 12'd1024;
`else
  localparam int NUM_KEYS  = 4;
`endif

endpackage

// File: rtl/dds_key_ctrl_if.sv
// Key-pulse / configuration bus between a key source (master) and dds_key_ctrl (slave).
// DDS_KEY_PHASE_EN adds key_phase and phase_word.
interface dds_key_ctrl_if;
  import dds_pkg::*;

  // Handshake: each key_* is a one-cycle pulse with no ready (the slave always captures it);
  // cfg_valid is a one-cycle strobe marking the first cycle new wave/step/freq values are shown.
  logic        key_wave;
  logic        key_step;
  logic        key_up;
  logic        key_down;
  logic [1:0]  wave_sel;
  logic [31:0] freq_word;
  logic [1:0]  step_idx;
  logic        cfg_valid;
  dds_state_e  state;
`ifdef DDS_KEY_PHASE_EN
  logic        key_phase;
  logic [11:0] phase_word;

  modport master (
    output key_wave, key_step, key_up, key_down, key_phase,
    input  wave_sel, freq_word, step_idx, cfg_valid, phase_word, state
  );
  modport slave (
    input  key_wave, key_step, key_up, key_down, key_phase,
    output wave_sel, freq_word, step_idx, cfg_valid, phase_word, state
  );
`else
  modport master (
    output key_wave, key_step, key_up, key_down,
    input  wave_sel, freq_word, step_idx, cfg_valid, state
  );
  modport slave (
    input  key_wave, key_step, key_up, key_down,
    output wave_sel, freq_word, step_idx, cfg_valid, state
  );
`endif

endinterface

// File: rtl/dds_freq_step.sv
// Combinational saturating add/subtract of a frequency word by one step,
// clamped to [FW_MIN, FW_MAX].
module dds_freq_step #(
  parameter logic [31:0] FW_MIN = 32'd86,
  parameter logic [31:0] FW_MAX = 32'd858993459
) (
  input  logic [31:0] freq_i,
  input  logic [31:0] step_i,
  input  logic        up_i,
  output logic [31:0] freq_o
);

  logic        [32:0] sum;
  logic signed [32:0] diff;

  assign sum  = {1'b0, freq_i} + {1'b0, step_i};
  // Signed so an underflow below zero compares as negative, not as a huge word
  assign diff = $signed({1'b0, freq_i}) - $signed({1'b0, step_i});

  always_comb begin
    freq_o = freq_i;
    if (up_i) begin
      freq_o = (sum > {1'b0, FW_MAX}) ? FW_MAX : sum[31:0];
    end else begin
      freq_o = (diff < $signed({1'b0, FW_MIN})) ? FW_MIN : diff[31:0];
    end
  end

endmodule

// File: rtl/dds_key_ctrl.sv
// DDS key controller: latches key pulses as pending requests, serves them one at a time
// through IDLE -> CALC -> COMMIT. Macro DDS_KEY_PHASE_EN adds the 90-degree phase key.
module dds_key_ctrl
  import dds_pkg::*;
#(
  parameter logic [31:0] FW_INIT = 32'd85899,
  parameter logic [31:0] FW_MIN  = 32'd86,
  parameter logic [31:0] FW_MAX  = 32'd858993459
) (
  input  logic           sys_clock,
  input  logic           sys_rst_n,
  dds_key_ctrl_if.slave  bus
);

  dds_state_e          state_q, state_d;
  logic [NUM_KEYS-1:0] key_in, pend_q, pend_d, sel_q, sel_d, clr;
  logic [1:0]          wave_q, wave_d, wave_sh_q, wave_sh_d;
  logic [1:0]          step_q, step_d, step_sh_q, step_sh_d;
  logic [31:0]         freq_q, freq_d, freq_sh_q, freq_sh_d, freq_calc;
  logic                valid_q, valid_d;
`ifdef DDS_KEY_PHASE_EN
  logic [11:0]         phase_q, phase_d, phase_sh_q, phase_sh_d;
`endif

  assign key_in[KEY_WAVE] = bus.key_wave;
  assign key_in[KEY_STEP] = bus.key_step;
  assign key_in[KEY_UP]   = bus.key_up;
  assign key_in[KEY_DOWN] = bus.key_down;
`ifdef DDS_KEY_PHASE_EN
  assign key_in[KEY_PHASE] = bus.key_phase;
`endif

  dds_freq_step #(.FW_MIN(FW_MIN), .FW_MAX(FW_MAX)) u_freq_step (
    .freq_i (freq_q),
    .step_i (STEP_LUT[step_q]),
    .up_i   (sel_q[KEY_UP]),
    .freq_o (freq_calc)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    clr       = '0;
    wave_d    = wave_q;
    step_d    = step_q;
    freq_d    = freq_q;
    wave_sh_d = wave_sh_q;
    step_sh_d = step_sh_q;
    freq_sh_d = freq_sh_q;
    valid_d   = 1'b0;
`ifdef DDS_KEY_PHASE_EN
    phase_d    = phase_q;
    phase_sh_d = phase_sh_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          // Scan low-to-high priority so the highest-priority pending key wins
          for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
              sel_d    = '0;
              sel_d[i] = 1'b1;
            end
          end
          clr     = sel_d;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        wave_sh_d = sel_q[KEY_WAVE] ? wave_q + 2'd1 : wave_q;
        step_sh_d = sel_q[KEY_STEP] ? step_q + 2'd1 : step_q;
        freq_sh_d = (sel_q[KEY_UP] | sel_q[KEY_DOWN]) ? freq_calc : freq_q;
`ifdef DDS_KEY_PHASE_EN
        phase_sh_d = sel_q[KEY_PHASE] ? phase_q + PHASE_INC : phase_q;
`endif
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        wave_d  = wave_sh_q;
        step_d  = step_sh_q;
        freq_d  = freq_sh_q;
`ifdef DDS_KEY_PHASE_EN
        phase_d = phase_sh_q;
`endif
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A pulse on an already-pending key is dropped, even on the edge that serves it
    pend_d = (pend_q & ~clr) | (key_in & ~pend_q);
  end

  always_ff @(posedge sys_clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      sel_q     <= '0;
      wave_q    <= WAVE_SINE;
      step_q    <= 2'd0;
      freq_q    <= FW_INIT;
      wave_sh_q <= WAVE_SINE;
      step_sh_q <= 2'd0;
      freq_sh_q <= FW_INIT;
      valid_q   <= 1'b0;
`ifdef DDS_KEY_PHASE_EN
      phase_q    <= 12'd0;
      phase_sh_q <= 12'd0;
`endif
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      sel_q     <= sel_d;
      wave_q    <= wave_d;
      step_q    <= step_d;
      freq_q    <= freq_d;
      wave_sh_q <= wave_sh_d;
      step_sh_q <= step_sh_d;
      freq_sh_q <= freq_sh_d;
      valid_q   <= valid_d;
`ifdef DDS_KEY_PHASE_EN
      phase_q    <= phase_d;
      phase_sh_q <= phase_sh_d;
`endif
    end
  end

  assign bus.wave_sel  = wave_q;
  assign bus.step_idx  = step_q;
  assign bus.freq_word = freq_q;
  assign bus.cfg_valid = valid_q;
  assign bus.state     = state_q;
`ifdef DDS_KEY_PHASE_EN
  assign bus.phase_word = phase_q;
`endif

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Directed bench for dds_key_ctrl: a vector table of key presses with hand-computed
// outputs, plus sequences for simultaneous keys, dropped pulses and mid-update reset.
module tb_dds_key_ctrl;
  import dds_pkg::*;

  localparam logic [31:0] FW_INIT = 32'd85899;
  localparam logic [31:0] FW_MIN  = 32'd86;
  localparam logic [31:0] FW_MAX  = 32'd858993459;
  localparam logic [31:0] FW_SAT  = 32'd858993359;
  localparam logic [3:0]  K_WAVE  = 4'b0001;
  localparam logic [3:0]  K_STEP  = 4'b0010;
  localparam logic [3:0]  K_UP    = 4'b0100;
  localparam logic [3:0]  K_DOWN  = 4'b1000;

  typedef struct {
    bit          which;
    logic [3:0]  keys;
    logic [1:0]  ew;
    logic [1:0]  es;
    logic [31:0] ef;
  } vec_t;

  logic        clk;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  dds_key_ctrl_if m_if ();
  dds_key_ctrl_if s_if ();

  dds_key_ctrl u_main (.sys_clock(clk), .sys_rst_n(rst_n), .bus(m_if));
  dds_key_ctrl #(.FW_INIT(FW_SAT)) u_sat (.sys_clock(clk), .sys_rst_n(rst_n), .bus(s_if));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached after %0d checks", checks);
    $fatal(1, "time limit");
  end

  // driver tasks
  task automatic set_keys(input bit which, input logic [3:0] k);
    if (which) begin
      s_if.key_wave = k[0]; s_if.key_step = k[1]; s_if.key_up = k[2]; s_if.key_down = k[3];
    end else begin
      m_if.key_wave = k[0]; m_if.key_step = k[1]; m_if.key_up = k[2]; m_if.key_down = k[3];
    end
  endtask

  task automatic snap(input bit which, output logic v, output logic [1:0] w,
                      output logic [1:0] s, output logic [31:0] f);
    if (which) begin
      v = s_if.cfg_valid; w = s_if.wave_sel; s = s_if.step_idx; f = s_if.freq_word;
    end else begin
      v = m_if.cfg_valid; w = m_if.wave_sel; s = m_if.step_idx; f = m_if.freq_word;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_keys(1'b0, 4'b0);
    set_keys(1'b1, 4'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called #1 after an edge: pulse keys, wait (bounded) for the strobe, check latency and values
  task automatic run_vec(input bit which, input logic [3:0] k, input logic [1:0] ew,
                         input logic [1:0] es, input logic [31:0] ef, input string name);
    logic v; logic [1:0] w, s; logic [31:0] f;
    int lat;
    lat = 0;
    set_keys(which, k);
    @(posedge clk); #1;
    set_keys(which, 4'b0);
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(posedge clk); #1;
      snap(which, v, w, s, f);
      if (v) lat = c;
    end
    check({name, "_latency"}, lat, 3);
    check({name, "_wave"}, w, ew);
    check({name, "_step"}, s, es);
    check({name, "_freq"}, f, ef);
    @(posedge clk); #1;
    snap(which, v, w, s, f);
    check({name, "_strobe_len"}, v, 1'b0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    logic        v;
    logic [1:0]  w, s;
    logic [31:0] f, e;
    int          n_strobe;
    vec_t        vecs[$];

    rst_n = 1'b0;
    set_keys(1'b0, 4'b0);
    set_keys(1'b1, 4'b0);
`ifdef DDS_KEY_PHASE_EN
    m_if.key_phase = 1'b0;
    s_if.key_phase = 1'b0;
`endif

    vecs.push_back('{1'b0, K_WAVE, 2'd1, 2'd0, FW_INIT});
    vecs.push_back('{1'b0, K_WAVE, 2'd2, 2'd0, FW_INIT});
    vecs.push_back('{1'b0, K_WAVE, 2'd3, 2'd0, FW_INIT});
    vecs.push_back('{1'b0, K_WAVE, 2'd0, 2'd0, FW_INIT});
    vecs.push_back('{1'b0, K_UP,   2'd0, 2'd0, 32'd85985});
    vecs.push_back('{1'b0, K_DOWN, 2'd0, 2'd0, 32'd85899});
    vecs.push_back('{1'b0, K_STEP, 2'd0, 2'd1, 32'd85899});
    vecs.push_back('{1'b0, K_UP,   2'd0, 2'd1, 32'd86758});
    vecs.push_back('{1'b0, K_STEP, 2'd0, 2'd2, 32'd86758});
    vecs.push_back('{1'b0, K_DOWN, 2'd0, 2'd2, 32'd78168});
    vecs.push_back('{1'b0, K_STEP, 2'd0, 2'd3, 32'd78168});
    vecs.push_back('{1'b0, K_DOWN, 2'd0, 2'd3, FW_MIN});
    vecs.push_back('{1'b0, K_DOWN, 2'd0, 2'd3, FW_MIN});
    vecs.push_back('{1'b0, K_UP,   2'd0, 2'd3, 32'd85985});
    vecs.push_back('{1'b0, K_STEP, 2'd0, 2'd0, 32'd85985});
    vecs.push_back('{1'b1, K_STEP, 2'd0, 2'd1, FW_SAT});
    vecs.push_back('{1'b1, K_STEP, 2'd0, 2'd2, FW_SAT});
    vecs.push_back('{1'b1, K_STEP, 2'd0, 2'd3, FW_SAT});
    vecs.push_back('{1'b1, K_UP,   2'd0, 2'd3, FW_MAX});
    vecs.push_back('{1'b1, K_UP,   2'd0, 2'd3, FW_MAX});

    repeat (3) @(posedge clk);
    #1;
    check("rst_wave", m_if.wave_sel, WAVE_SINE);
    check("rst_step", m_if.step_idx, 2'd0);
    check("rst_freq", m_if.freq_word, FW_INIT);
    check("rst_valid", m_if.cfg_valid, 1'b0);
    check("rst_state", 32'(m_if.state), 32'(ST_IDLE));
    check("rst_sat_freq", s_if.freq_word, FW_SAT);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_vec(vecs[i].which, vecs[i].keys, vecs[i].ew, vecs[i].es, vecs[i].ef,
              $sformatf("vec%0d", i));

    // wave and up in the same cycle: wave at N+3, up at N+6
    set_keys(1'b0, K_WAVE | K_UP);
    @(posedge clk); #1;
    set_keys(1'b0, 4'b0);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      snap(1'b0, v, w, s, f);
      check($sformatf("dual_valid_c%0d", c), v, (c == 3 || c == 6));
      if (c == 3) begin
        check("dual_wave", w, 2'd1);
        check("dual_freq_hold", f, 32'd85985);
      end
      if (c == 6) check("dual_freq", f, 32'd86071);
    end
    repeat (3) @(posedge clk);
    #1;

    // second up pulse while up is still pending is dropped
    set_keys(1'b0, K_WAVE | K_UP);
    @(posedge clk); #1;
    set_keys(1'b0, K_UP);
    @(posedge clk); #1;
    set_keys(1'b0, 4'b0);
    n_strobe = 0;
    for (int c = 2; c <= 14; c++) begin
      @(posedge clk); #1;
      snap(1'b0, v, w, s, f);
      if (v) n_strobe++;
    end
    check("drop_strobes", n_strobe, 2);
    check("drop_wave", w, 2'd2);
    check("drop_freq", f, 32'd86157);

    // ten down presses from reset at the 1 Hz step
    do_reset();
    for (int k = 1; k <= 10; k++) exp_q.push_back(FW_INIT - 32'(86 * k));
    for (int k = 1; k <= 10; k++) begin
      e = exp_q.pop_front();
      run_vec(1'b0, K_DOWN, 2'd0, 2'd0, e, $sformatf("down%0d", k));
    end
    snap(1'b0, v, w, s, f);
    check("down10_final", f, 32'd85039);

    // reset during CALC aborts the update
    set_keys(1'b0, K_UP);
    @(posedge clk); #1;
    set_keys(1'b0, 4'b0);
    @(posedge clk); #1;
    check("abort_calc_state", 32'(m_if.state), 32'(ST_CALC));
    rst_n = 1'b0;
    #1;
    check("abort_calc_freq", m_if.freq_word, FW_INIT);
    check("abort_calc_state_rst", 32'(m_if.state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_strobe = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (m_if.cfg_valid) n_strobe++;
    end
    check("abort_calc_strobes", n_strobe, 0);
    check("abort_calc_idle", 32'(m_if.state), 32'(ST_IDLE));
    check("abort_calc_freq_after", m_if.freq_word, FW_INIT);

    // reset during COMMIT aborts too; first key right after release is accepted
    set_keys(1'b0, K_UP);
    @(posedge clk); #1;
    set_keys(1'b0, 4'b0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_commit_state", 32'(m_if.state), 32'(ST_COMMIT));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(1'b0, K_WAVE, 2'd1, 2'd0, FW_INIT, "post_rst_wave");
    check("abort_commit_freq", m_if.freq_word, FW_INIT);

`ifdef DDS_KEY_PHASE_EN
    for (int k = 0; k < 5; k++) begin
      m_if.key_phase = 1'b1;
      @(posedge clk); #1;
      m_if.key_phase = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("phase%0d_valid", k), m_if.cfg_valid, 1'b1);
      check($sformatf("phase%0d_word", k), m_if.phase_word, 12'(1024 * (k + 1)));
      repeat (3) @(posedge clk);
      #1;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_key_ctrl.md
DDS_KEY_CTRL -- requirements
Module: dds_key_ctrl

Interface
REQ-001 Parameter FW_INIT, default 32'd85899, reset frequency word (1 kHz at 50 MHz).
REQ-002 Parameter FW_MIN, default 32'd86, lowest legal frequency word.
REQ-003 Parameter FW_MAX, default 32'd858993459, highest legal frequency word (10 MHz).
REQ-004 sys_clock  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-005 sys_rst_n  input  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-006 key_wave  input  1  one-cycle debounced press pulse: cycle waveform.
REQ-007 key_step  input  1  one-cycle debounced press pulse: cycle step size.
REQ-008 key_up  input  1  one-cycle debounced press pulse: raise frequency.
REQ-009 key_down  input  1  one-cycle debounced press pulse: lower frequency.
REQ-010 wave_sel  output  2  0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-011 freq_word  output  32  DDS phase-accumulator increment.
REQ-012 step_idx  output  2  current step: 0=1 Hz, 1=10 Hz, 2=100 Hz, 3=1 kHz.
REQ-013 cfg_valid  output  1  one-cycle strobe, high in the cycle new outputs first appear.

Function
REQ-014 Every key input pulse is captured into its own pending bit on the same clock edge, whatever the FSM state.
REQ-015 A pulse that arrives while its pending bit is already set is dropped; no counting.
REQ-016 FSM states: IDLE, CALC, COMMIT; reset state IDLE.
REQ-017 IDLE -> CALC when any pending bit is set; the highest-priority bit is selected and cleared on that edge.
REQ-018 Priority: wave > step > up > down.
REQ-019 CALC: next value is computed into internal shadow registers; outputs unchanged. CALC -> COMMIT unconditionally.
REQ-020 COMMIT: shadow values go to outputs, cfg_valid=1 for exactly this cycle; COMMIT -> IDLE unconditionally.
REQ-021 Latency: pulse at edge N in IDLE with no other pending gives updated outputs and cfg_valid at edge N+3.
REQ-022 Wave: wave_sel+1 mod 4 (3 -> 0).
REQ-023 Step: step_idx+1 mod 4 (3 -> 0).
REQ-024 Up: freq_word + STEP_LUT[step_idx] in 33-bit arithmetic; a result above FW_MAX saturates to FW_MAX.
REQ-025 Down: freq_word - STEP_LUT[step_idx] in signed 33-bit arithmetic; a result below FW_MIN saturates to FW_MIN.
REQ-026 The COMMIT cycle and cfg_valid still occur when saturation leaves the value unchanged.
REQ-027 Up and down pending together are processed sequentially, up first; they never cancel.

Reset
REQ-028 Async assert: wave_sel=0, step_idx=0, freq_word=FW_INIT, cfg_valid=0, all pending bits cleared, FSM=IDLE.
REQ-029 Reset asserted during CALC or COMMIT aborts the update; no cfg_valid is emitted.
REQ-030 First key pulse accepted is on the first rising edge after deassertion.

Configuration
REQ-031 Macro DDS_KEY_PHASE_EN defined: adds input key_phase (priority lowest, below down) and output phase_word [11:0], reset 0.
REQ-032 Under DDS_KEY_PHASE_EN, each key_phase press adds 12'd1024 to phase_word (90 degrees) with wrap-around, commits via the same FSM and strobe.
REQ-033 DDS_KEY_PHASE_EN undefined: neither port nor any phase logic exists.

Structure
REQ-034 Package dds_pkg holds the wave encoding constants, the STEP_LUT constants {86, 859, 8590, 85899}, and the FSM state encoding.
REQ-035 Sub-module dds_freq_step (combinational saturating add/sub of freq_word by STEP_LUT entry between FW_MIN and FW_MAX) is instantiated once.

Verification
REQ-036 Reset, then 4 key_wave pulses spaced 10 cycles -> wave_sel 1,2,3,0, four cfg_valid strobes each 3 cycles after the pulse.
REQ-037 step_idx=3, freq_word=FW_MAX-100, key_up -> freq_word=FW_MAX; second key_up -> unchanged, cfg_valid still pulses.
REQ-038 From reset (step 0) key_down 10 times -> freq_word=85899-860=85039.
REQ-039 key_wave and key_up in the same cycle -> wave_sel changes at N+3, freq_word +86 at N+6, two strobes.
REQ-040 key_up pulse, then sys_rst_n low during CALC -> freq_word=85899, no cfg_valid, FSM IDLE after release.
REQ-041 With DDS_KEY_PHASE_EN, 5 key_phase pulses -> phase_word 1024, 2048, 3072, 0, 1024.
